// File: rtl/tdm_demux4_pkg.sv
// tdm_demux4_pkg: shared state type and channel/slot constants for the TDM demux
package tdm_demux4_pkg;
  typedef enum logic {HUNT, RUN} state_t;
  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;
endpackage

// File: rtl/tdm_demux4_slot_counter.sv
// tdm_slot_counter: modulo-4 slot counter with synchronous load-to-1 and increment enable
module tdm_slot_counter
  import tdm_demux4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  output logic [SLOT_W-1:0] cnt
);
  // a sync sample always occupies slot 0, so the next slot is 1; otherwise count and wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= SLOT_W'(1);
    else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: four-channel TDM demultiplexer with frame-sync alignment and double-buffered outputs
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             frame_done,
  output logic             sync_err
);
  state_t state;
  logic [WIDTH-1:0] shadow [NUM_CH-1];
  logic load, inc, last, realign, wr;
  logic [SLOT_W-1:0] wr_idx;
  assign load    = din_valid && frame_sync;
  assign inc     = din_valid && !frame_sync && state == RUN;
  assign last    = inc && slot == SLOT_W'(NUM_CH - 1);
  assign realign = load && state == RUN && slot != '0;
  assign wr      = load || (inc && !last);
  assign wr_idx  = frame_sync ? '0 : slot;
  assign locked  = state == RUN;
  tdm_slot_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .inc   (inc),
    .cnt   (slot)
  );
  // slot-3 sample bypasses the shadow bank so the whole frame lands on A..D in one edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= HUNT;
      A          <= '0;
      B          <= '0;
      C          <= '0;
      D          <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      for (int i = 0; i < NUM_CH - 1; i++) shadow[i] <= '0;
    end else begin
      frame_done <= last;
      sync_err   <= realign;
      if (load) state <= RUN;
      if (wr) shadow[wr_idx] <= din;
      if (last) begin
        A <= shadow[0];
        B <= shadow[1];
        C <= shadow[2];
        D <= din;
      end
    end
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: randomized and directed checks of tdm_demux4 against a queue-based frame model
module tb_tdm_demux4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] a, b, c, d;
  logic [1:0] slot;
  logic       locked, frame_done, sync_err;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  bit         mlock;
  logic [7:0] mo[4];
  bit         mdone, merr;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .A          (a),
    .B          (b),
    .C          (c),
    .D          (d),
    .slot       (slot),
    .locked     (locked),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    mlock = 0;
    foreach (mo[i]) mo[i] = '0;
    mdone = 0;
    merr  = 0;
  endfunction

  task automatic check_all();
    chk("A", a, mo[0]);
    chk("B", b, mo[1]);
    chk("C", c, mo[2]);
    chk("D", d, mo[3]);
    chk("slot", slot, q.size());
    chk("locked", locked, mlock);
    chk("frame_done", frame_done, mdone);
    chk("sync_err", sync_err, merr);
  endtask

  task automatic step(input bit v, input bit s, input logic [7:0] x);
    @(negedge clk);
    din_valid  = v;
    frame_sync = s;
    din        = x;
    @(posedge clk);
    mdone = 0;
    merr  = 0;
    if (v) begin
      if (s) begin
        merr  = mlock && q.size() != 0;
        mlock = 1;
        q.delete();
        q.push_back(x);
      end else if (mlock) begin
        q.push_back(x);
        if (q.size() == 4) begin
          foreach (mo[i]) mo[i] = q[i];
          q.delete();
          mdone = 1;
        end
      end
    end
    #1 check_all();
  endtask

  task automatic frame(input logic [7:0] s0, s1, s2, s3);
    step(1, 1, s0);
    step(1, 0, s1);
    step(1, 0, s2);
    step(1, 0, s3);
  endtask

  initial begin
    int dones;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    frame(8'h11, 8'h22, 8'h33, 8'h44);
    chk("t1_A", a, 8'h11);
    chk("t1_D", d, 8'h44);
    chk("t1_done", frame_done, 1);
    chk("t1_locked", locked, 1);
    step(1, 0, 8'h99);
    chk("t1_done_pulse", frame_done, 0);

    model_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(1, 0, 8'hAA);
    step(1, 0, 8'hBB);
    chk("t2_hunt_locked", locked, 0);
    frame(8'h01, 8'h02, 8'h03, 8'h04);
    chk("t2_B", b, 8'h02);

    step(1, 1, 8'h11);
    step(0, 1, 8'hFF);
    step(1, 0, 8'h22);
    step(0, 1, 8'hFF);
    step(0, 1, 8'hFF);
    step(1, 0, 8'h33);
    step(0, 1, 8'hFF);
    step(1, 0, 8'h44);
    chk("t3_C", c, 8'h33);
    chk("t3_done", frame_done, 1);

    step(1, 1, 8'h0F);
    step(1, 0, 8'h10);
    step(1, 0, 8'h20);
    step(1, 1, 8'h50);
    chk("t4_err", sync_err, 1);
    chk("t4_hold_A", a, 8'h11);
    step(1, 0, 8'h60);
    step(1, 0, 8'h70);
    step(1, 0, 8'h80);
    chk("t4_A", a, 8'h50);
    chk("t4_D", d, 8'h80);

    dones = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        step(1, k == 0, 8'(8'h30 * f + k));
        dones += int'(frame_done);
      end
      chk("t5_done_each", frame_done, 1);
    end
    chk("t5_dones", dones, 3);

    step(1, 1, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 0, 8'hA3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b1;
    step(1, 0, 8'hA4);
    step(1, 0, 8'hA5);
    frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    chk("t6_A", a, 8'hC1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
